sram_mem_controller: RTL
========================

# sram_mem_controller

Multi-cycle data-memory controller between the processor MEM stage and an external 16-bit asynchronous SRAM. It accepts one 32-bit word read or write per request and splits it into two 16-bit half-word SRAM accesses. It holds `ready` low to freeze the pipeline, both with and without forwarding, until the access completes. It replaces the single-cycle data memory and is the stage directly downstream of MEM-stage address/data generation.

## Interface
- `WAIT_CYCLES`, 2, cycles per half-word SRAM phase; legal range 2..15.
- `DATA_BASE`, 1024, byte address mapped to SRAM word 0.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset. Asynchronous, active-high. Clock is `clk`, reset is `rst`; one clock domain.
- `rd_en` in 1: MEM-stage read request; level, held while `ready`=0.
- `wr_en` in 1: MEM-stage write request; level, held while `ready`=0.
- `address` in 32: byte address from ALU result.
- `write_data` in 32: store data (Rm value after forwarding).
- `read_data` out 32: loaded word.
- `ready` out 1: 1 means the MEM stage may advance; 0 freezes the pipeline.
- `addr_err` out 1: one-cycle out-of-range pulse (see Configuration).
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_o` out 16: SRAM write data.
- `sram_dq_i` in 16: SRAM read data.
- `sram_dq_oe` out 1: 1 means the top level drives the DQ bus with `sram_dq_o`.
- `sram_we_n` out 1: SRAM write enable, active-low.

## Operation
- Word index `w = (address - DATA_BASE) >> 2`, using bits [16:0]. Low half goes to `sram_addr = {w,1'b0}` and holds data[15:0]. High half goes to `{w,1'b1}` and holds data[31:16]. Bits [1:0] of `address` are ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE: if `wr_en|rd_en`, latch address, data and op, then go to LOW. If both are set, the write wins. Otherwise stay in IDLE.
- LOW: WAIT_CYCLES cycles, counted by a 4-bit counter, then go to HIGH.
- HIGH: WAIT_CYCLES cycles, then go to DONE.
- DONE: one cycle, then go to IDLE.
- `ready` (combinational) = (state==IDLE & ~rd_en & ~wr_en) | state==DONE.
- Write phase:
  - `sram_dq_oe`=1 and `sram_dq_o` equals the half's data for the whole phase.
  - `sram_we_n`=0 in every cycle of the phase except the last, which gives data and address hold.
- Read phase:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `sram_dq_i` is sampled on the final edge of the phase: LOW fills [15:0], HIGH fills [31:16].
  - `read_data` updates only at the end of HIGH. It is valid in DONE and held until the next read completes.
- Request changes after capture are ignored until DONE.
- If a request is still asserted in the cycle after DONE, it is treated as a new access. The pipeline has advanced, so it is a new instruction.
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, `sram_we_n`=1, `addr_err`=0.
- `ready`=1 in reset while no request is present.
- Reset mid-access: the controller aborts to IDLE immediately and `sram_we_n` returns to 1 asynchronously. A partial write (low half only) is acceptable.

## Timing
- All SRAM-side outputs are registered and change on the edge that enters or advances a phase.
- Request first seen in cycle k (IDLE):
  - LOW spans cycles k+1..k+W.
  - HIGH spans k+W+1..k+2W.
  - DONE and `ready`=1 occur in cycle k+2W+1.
  - The pipeline advances on the edge ending that cycle.
- Total stall is 2W+1 cycles; with W=2, `ready` is low for 5 cycles.
- Back-to-back requests: there is no bubble beyond the single IDLE capture cycle.

## Configuration
- `SRAM_RANGE_CHECK_EN` defined:
  - Condition: `address < DATA_BASE` or `address - DATA_BASE >= 2^19`.
  - Effect: IDLE goes straight to DONE with no SRAM activity (`sram_we_n` stays 1, `sram_dq_oe` stays 0).
  - `addr_err`=1 during that DONE cycle.
  - A read returns `read_data`=0.
- Undefined: no check is made, addresses wrap modulo 2^19 bytes, and `addr_err` is tied 0.

## Test plan
- Reset: assert `rst` for 1 cycle with no request. Required: `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0.
- Write at W=2: `wr_en`, `address`=1024, `write_data`=0x12345678. Required:
  - `sram_addr`=0 with 0x5678, then `sram_addr`=1 with 0x1234.
  - `sram_we_n` low for 1 cycle per phase.
  - `ready` low 5 cycles, then high 1 cycle.
- Read-back: `rd_en`, `address`=1024, with an SRAM model holding the write above. Required: `read_data`=0x12345678 in DONE, `sram_dq_oe`=0 throughout.
- Simultaneous request: `rd_en`=`wr_en`=1, `address`=1028, `write_data`=0xCAFEBABE. Required: write to half-words 2 and 3; `read_data` unchanged.
- Reset mid-write: assert `rst` during the HIGH phase. Required: `sram_we_n`=1 asynchronously, state IDLE, `ready`=1 once requests drop.
- Range check (`SRAM_RANGE_CHECK_EN` defined): `rd_en`, `address`=512. Required: `ready` high on cycle k+1, `addr_err` pulses once, `read_data`=0, no SRAM strobe.

Source files
------------

// File: rtl/sram_mem_controller_if.sv
// MEM-stage side of the SRAM data-memory controller: request, address/data and
// the ready/addr_err status returned to the pipeline.
interface sram_mem_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready, addr_err
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready, addr_err
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit async SRAM phases and stalls
// the pipeline via ready. Optional address range check: SRAM_RANGE_CHECK_EN.
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_controller_if.slave  bus,
  output logic [17:0]           sram_addr,
  output logic [15:0]           sram_dq_o,
  input  logic [15:0]           sram_dq_i,
  output logic                  sram_dq_oe,
  output logic                  sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [16:0] word_q, word_d;
  logic [15:0] rlow_q, rlow_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] sram_dq_o_q, sram_dq_o_d;
  logic        sram_dq_oe_q, sram_dq_oe_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] offset;
  logic [16:0] word_idx;
  logic        out_of_range;
  logic        request;

  assign offset   = bus.address - DATA_BASE;
  assign word_idx = offset[18:2];
  assign request  = bus.wr_en | bus.rd_en;

`ifdef SRAM_RANGE_CHECK_EN
  assign out_of_range = (bus.address < DATA_BASE) || (offset[31:19] != 13'd0);
`else
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    rlow_d       = rlow_q;
    read_data_d  = read_data_q;
    sram_addr_d  = sram_addr_q;
    sram_dq_o_d  = sram_dq_o_q;
    sram_dq_oe_d = sram_dq_oe_q;
    sram_we_n_d  = sram_we_n_q;
    addr_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (request) begin
          // Write wins when both requests are raised together.
          is_write_d = bus.wr_en;
          wdata_d    = bus.write_data;
          word_d     = word_idx;
          cnt_d      = 4'd0;
          if (out_of_range) begin
            state_d    = DONE;
            addr_err_d = 1'b1;
            if (!bus.wr_en) read_data_d = 32'd0;
          end else begin
            state_d      = LOW;
            sram_addr_d  = {word_idx, 1'b0};
            sram_dq_o_d  = bus.wr_en ? bus.write_data[15:0] : sram_dq_o_q;
            sram_dq_oe_d = bus.wr_en;
            sram_we_n_d  = ~bus.wr_en;
          end
        end
      end

      LOW: begin
        if (cnt_q == LAST_CNT) begin
          state_d     = HIGH;
          cnt_d       = 4'd0;
          rlow_d      = sram_dq_i;
          sram_addr_d = {word_q, 1'b1};
          sram_dq_o_d = is_write_q ? wdata_q[31:16] : sram_dq_o_q;
          sram_we_n_d = ~is_write_q;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          // Strobe released one cycle early so data and address are held past it.
          sram_we_n_d = is_write_q ? (cnt_q + 4'd1 == LAST_CNT) : 1'b1;
        end
      end

      HIGH: begin
        if (cnt_q == LAST_CNT) begin
          state_d      = DONE;
          cnt_d        = 4'd0;
          sram_dq_oe_d = 1'b0;
          sram_we_n_d  = 1'b1;
          if (!is_write_q) read_data_d = {sram_dq_i, rlow_q};
        end else begin
          cnt_d       = cnt_q + 4'd1;
          sram_we_n_d = is_write_q ? (cnt_q + 4'd1 == LAST_CNT) : 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      is_write_q   <= 1'b0;
      wdata_q      <= 32'd0;
      word_q       <= 17'd0;
      rlow_q       <= 16'd0;
      read_data_q  <= 32'd0;
      sram_addr_q  <= 18'd0;
      sram_dq_o_q  <= 16'd0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      rlow_q       <= rlow_d;
      read_data_q  <= read_data_d;
      sram_addr_q  <= sram_addr_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_we_n_q  <= sram_we_n_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.ready     = ((state_q == IDLE) & ~bus.rd_en & ~bus.wr_en) | (state_q == DONE);
  assign bus.read_data = read_data_q;
  assign bus.addr_err  = addr_err_q;
  assign sram_addr     = sram_addr_q;
  assign sram_dq_o     = sram_dq_o_q;
  assign sram_dq_oe    = sram_dq_oe_q;
  assign sram_we_n     = sram_we_n_q;

endmodule
